sr_latch_bank_ctrl: RTL

Sequences writes into a bank of N gated SR latches and shares the bank between two requesters (A and B).
- Round-robin arbitration between A and B.
- Drives per-latch S/R/E with setup, enable-pulse and hold phases.
- Never drives the invalid S=R=1 combination.
- Checks the latch Q readback after each write and flags mismatches.

---
 rtl/sr_ctrl_pkg.sv | 31 +++
 rtl/rr_arbiter2.sv | 49 ++++
 rtl/sr_latch_bank_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sr_ctrl_pkg
// Shared types and constants for the SR latch bank controller:
//   state_t    FSM state encoding (IDLE, SETUP, PULSE, HOLD, DONE)
//   OP_SET / OP_RESET  requester operation encoding
//   SIDE_A / SIDE_B    bit positions of the two requesters in REQ/GNT
//   pulse_len()        effective enable-pulse length (at least one cycle)
// ---------------------------------------------------------------------------
package sr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

    localparam int SIDE_A = 0;
    localparam int SIDE_B = 1;

    // A zero or negative pulse length would leave the latch unwritten,
    // so it is clamped to one cycle.
    function automatic int pulse_len(input int pulse_cyc);
        return (pulse_cyc < 1) ? 1 : pulse_cyc;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. A lone requester always wins; when both
// request, the side named by the pointer wins. The pointer moves to the
// loser whenever ADV is pulsed together with a grant.
// Ports:
//   CLK  in   clock, rising edge
//   RST  in   synchronous active-high reset (pointer back to A)
//   REQ  in   [1:0] requests, bit SIDE_A = A, bit SIDE_B = B
//   ADV  in   grant accepted this cycle; advance the pointer
//   GNT  out  [1:0] one-hot (or zero) grant, combinational from REQ/PTR
//   PTR  out  current priority side: 0 = A, 1 = B
// ---------------------------------------------------------------------------
module rr_arbiter2
    import sr_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] REQ,
    input  logic       ADV,
    output logic [1:0] GNT,
    output logic       PTR
);

    always_comb begin
        // NOTE: GNT gets a default before any branch so every path assigns it
        // and no latch is inferred.
        GNT = 2'b00;
        if (REQ[SIDE_A] && REQ[SIDE_B]) begin
            GNT[PTR] = 1'b1;
        end else if (REQ[SIDE_A]) begin
            GNT[SIDE_A] = 1'b1;
        end else if (REQ[SIDE_B]) begin
            GNT[SIDE_B] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (RST) begin
            PTR <= 1'b0;
        end else if (ADV && (GNT != 2'b00)) begin
            // Winner A hands priority to B (1), winner B hands it to A (0).
            PTR <= GNT[SIDE_A];
        end
    end

endmodule

// File: rtl/sr_latch_bank_ctrl.sv
// ---------------------------------------------------------------------------
// sr_latch_bank_ctrl
// Shares a bank of N gated SR latches between requesters A and B. Each
// granted write runs SETUP (S/R valid, E low), PULSE (E high PULSE_CYC
// cycles), HOLD (E low, S/R still valid) and DONE (all drives low, ACK and
// readback check). S and R are never high together and E is zero or one-hot.
// Every output is a register loaded from the state the FSM was in during the
// previous cycle, so outputs trail the state register by one cycle.
// Ports:
//   CLK         in   clock, rising edge
//   RST         in   synchronous active-high reset
//   REQA/REQB   in   write requests, held until the matching ACK
//   OPA/OPB     in   1 = set, 0 = reset
//   ADDRA/ADDRB in   [AW-1:0] latch index
//   QIN         in   [N-1:0] latch Q readback
//   ACKA/ACKB   out  one-cycle completion pulses
//   S/R/E       out  [N-1:0] per-latch set, reset and enable drives
//   BUSY        out  high while a write sequence is in progress
//   ERR         out  one-cycle pulse: readback mismatch or address >= N
// ---------------------------------------------------------------------------
module sr_latch_bank_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int N         = 4,
    parameter int AW        = 2,
    parameter int PULSE_CYC = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQA,
    input  logic          OPA,
    input  logic [AW-1:0] ADDRA,
    input  logic          REQB,
    input  logic          OPB,
    input  logic [AW-1:0] ADDRB,
    input  logic [N-1:0]  QIN,
    output logic          ACKA,
    output logic          ACKB,
    output logic [N-1:0]  S,
    output logic [N-1:0]  R,
    output logic [N-1:0]  E,
    output logic          BUSY,
    output logic          ERR
);

    localparam int            PULSE_LEN = pulse_len(PULSE_CYC);
    localparam int            CW        = $clog2(PULSE_LEN) + 1;
    localparam logic [CW-1:0] CNT_LOAD  = CW'(PULSE_LEN - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cap_op;
    logic [AW-1:0] cap_addr;

    logic [1:0]    gnt;
    logic          rr_ptr;
    logic          grant_adv;

    logic          addr_ok;
    logic [N-1:0]  sel;
    logic [N-1:0]  drive_s;
    logic [N-1:0]  drive_r;
    logic          readback;

    assign grant_adv = (state == ST_IDLE) && (gnt != 2'b00);

    rr_arbiter2 u_arb (
        .CLK (CLK),
        .RST (RST),
        .REQ ({REQB, REQA}),
        .ADV (grant_adv),
        .GNT (gnt),
        .PTR (rr_ptr)
    );

    // An out-of-range index selects no latch at all, so nothing is driven
    // in any phase while the sequence and its timing stay unchanged.
    assign addr_ok  = (int'(cap_addr) < N);
    assign sel      = addr_ok ? (N'(1) << cap_addr) : '0;
    assign drive_s  = (cap_op == OP_SET)   ? sel : '0;
    assign drive_r  = (cap_op == OP_RESET) ? sel : '0;
    assign readback = |(QIN & sel);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cap_op   <= OP_RESET;
            cap_addr <= '0;
            S        <= '0;
            R        <= '0;
            E        <= '0;
            ACKA     <= 1'b0;
            ACKB     <= 1'b0;
            BUSY     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            // Drives default low; the phase being left decides what is
            // presented during the next cycle.
            S    <= '0;
            R    <= '0;
            E    <= '0;
            ACKA <= 1'b0;
            ACKB <= 1'b0;
            ERR  <= 1'b0;
            BUSY <= (state != ST_IDLE);

            unique case (state)
                ST_IDLE: begin
                    if (gnt != 2'b00) begin
                        cap_op   <= gnt[SIDE_B] ? OPB   : OPA;
                        cap_addr <= gnt[SIDE_B] ? ADDRB : ADDRA;
                        state    <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    S     <= drive_s;
                    R     <= drive_r;
                    cnt   <= CNT_LOAD;
                    state <= ST_PULSE;
                end

                ST_PULSE: begin
                    S <= drive_s;
                    R <= drive_r;
                    E <= sel;
                    if (cnt == '0) begin
                        state <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_HOLD: begin
                    // S/R stay driven across the falling edge of E.
                    S     <= drive_s;
                    R     <= drive_r;
                    state <= ST_DONE;
                end

                ST_DONE: begin
                    // The pointer moved to the loser at grant time and cannot
                    // move again until IDLE, so it identifies the winner.
                    ACKA  <= rr_ptr;
                    ACKB  <= ~rr_ptr;
                    ERR   <= !addr_ok || (readback != cap_op);
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
